// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ALU opcode and forwarding-select types for the execute stage.
package pipeline_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_BNE = 4'b0011,
    ALU_OR  = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_BGE = 4'b0110,
    ALU_BLT = 4'b0111,
    ALU_EQ  = 4'b1000
  } alu_op_t;
  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;
endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: picks the freshest source for each EX operand, never matching x0.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output fwd_sel_t              fwd_a,
  output fwd_sel_t              fwd_b
);
  logic w_exmem_ok, w_memwb_ok;
  assign w_exmem_ok = exmem_reg_write & (exmem_rd != '0);
  assign w_memwb_ok = memwb_reg_write & (memwb_rd != '0);
  always_comb begin
    fwd_a = (w_exmem_ok && exmem_rd == ex_rs1) ? FWD_EXMEM :
            (w_memwb_ok && memwb_rd == ex_rs1) ? FWD_MEMWB : FWD_REG;
    fwd_b = (w_exmem_ok && exmem_rd == ex_rs2) ? FWD_EXMEM :
            (w_memwb_ok && memwb_rd == ex_rs2) ? FWD_MEMWB : FWD_REG;
  end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with operand forwarding, load-use detection and bubble insertion.
module ex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall_in,
  input  logic                     flush_in,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_alu_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_wb_data,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     load_use_stall
);
  logic                     r_valid, r_alu_src, r_reg_write, r_mem_read, r_mem_write;
  logic [REG_ADDR_W-1:0]    r_rs1, r_rs2, r_rd;
  logic [DATA_WIDTH-1:0]    r_rs1_data, r_rs2_data, r_imm;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic                     w_load, w_bubble, w_take;
  logic [DATA_WIDTH-1:0]    w_rs1_fwd, w_rs2_fwd;
  fwd_sel_t                 w_fwd_a, w_fwd_b;

  assign load_use_stall = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                          ((r_rd == id_rs1) | (r_rd == id_rs2));
  // Flush overrides stall; a load-use bubble only lands when the stage is not held.
  assign w_load   = flush_in | ~stall_in;
  assign w_bubble = flush_in | load_use_stall;
  assign w_take   = ~w_bubble & id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_op        <= '0;
    end else if (w_load) begin
      r_valid     <= w_take;
      r_alu_src   <= id_alu_src;
      r_reg_write <= w_take & id_reg_write;
      r_mem_read  <= w_take & id_mem_read;
      r_mem_write <= w_take & id_mem_write;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= w_bubble ? '0 : id_rd;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_op        <= w_bubble ? '0 : id_operation;
    end
  end

  forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .ex_rs1          (r_rs1),
    .ex_rs2          (r_rs2),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_a           (w_fwd_a),
    .fwd_b           (w_fwd_b)
  );

  assign w_rs1_fwd = (w_fwd_a == FWD_EXMEM) ? exmem_alu_result :
                     (w_fwd_a == FWD_MEMWB) ? memwb_wb_data : r_rs1_data;
  assign w_rs2_fwd = (w_fwd_b == FWD_EXMEM) ? exmem_alu_result :
                     (w_fwd_b == FWD_MEMWB) ? memwb_wb_data : r_rs2_data;

  assign SrcA          = w_rs1_fwd;
  assign SrcB          = r_alu_src ? r_imm : w_rs2_fwd;
  assign ex_store_data = w_rs2_fwd;
  assign Operation     = r_op;
  assign ex_valid      = r_valid;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: table-driven capture checks through a scoreboard, plus hand sequences for corners.
module tb_ex_operand_stage;
  import pipeline_pkg::*;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        alu_src, valid, rw, mw;
    logic [3:0]  op;
  } vec_t;

  typedef struct {
    logic [31:0] srca, srcb, store;
    logic [3:0]  op;
    logic        valid, rw, mw;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_alu_result, memwb_wb_data;
  logic [3:0]  id_operation;
  logic        stall_in, flush_in, exmem_reg_write, memwb_reg_write;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  int   n_pass = 0, n_total = 0;
  vec_t tbl[10];
  exp_t sb[$];

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_operation(id_operation), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall_in(stall_in), .flush_in(flush_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wb_data(memwb_wb_data),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_src = 0;
    id_operation = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    stall_in = 0; flush_in = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_alu_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_wb_data = 0;
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_data = v.rs1_data; id_rs2_data = v.rs2_data; id_imm = v.imm;
    id_alu_src = v.alu_src; id_operation = v.op; id_reg_write = v.rw;
    id_mem_read = 0; id_mem_write = v.mw;
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.srca  = v.rs1_data;
    e.srcb  = v.alu_src ? v.imm : v.rs2_data;
    e.store = v.rs2_data;
    e.op    = v.op;
    e.valid = v.valid;
    e.rw    = v.valid & v.rw;
    e.mw    = v.valid & v.mw;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic capture(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic src, input logic [3:0] op, input logic mr);
    @(negedge clk);
    idle();
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_operation = op; id_reg_write = 1; id_mem_read = mr;
    tick();
  endtask

  initial begin
    exp_t e;
    idle();
    for (int i = 0; i < 10; i++) begin
      tbl[i].rs1 = 5'($urandom_range(31, 1)); tbl[i].rs2 = 5'($urandom_range(31, 1));
      tbl[i].rd = 5'($urandom_range(31, 1));
      tbl[i].rs1_data = $urandom; tbl[i].rs2_data = $urandom; tbl[i].imm = $urandom;
      tbl[i].alu_src = 1'(i % 2); tbl[i].op = 4'(i % 9);
      tbl[i].valid = (i != 3 && i != 7); tbl[i].rw = 1'b1; tbl[i].mw = 1'(i % 3 == 0);
    end

    #12;
    chk("reset_srca", SrcA, 0);
    chk("reset_srcb", SrcB, 0);
    chk("reset_op", 32'(Operation), 0);
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_lus", 32'(load_use_stall), 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(model(tbl[i]));
      tick();
      e = sb.pop_front();
      chk("tbl_srca", SrcA, e.srca);
      chk("tbl_srcb", SrcB, e.srcb);
      chk("tbl_store", ex_store_data, e.store);
      chk("tbl_op", 32'(Operation), 32'(e.op));
      chk("tbl_valid", 32'(ex_valid), 32'(e.valid));
      chk("tbl_rw", 32'(ex_reg_write), 32'(e.rw));
      chk("tbl_mw", 32'(ex_mem_write), 32'(e.mw));
    end

    capture(5'd1, 5'd2, 5'd6, 32'd5, 32'd9, 32'd7, 1'b1, ALU_ADD, 1'b0);
    chk("cap_srca", SrcA, 5);
    chk("cap_srcb", SrcB, 7);
    chk("cap_op", 32'(Operation), 32'(ALU_ADD));
    chk("cap_valid", 32'(ex_valid), 1);

    capture(5'd3, 5'd3, 5'd8, 32'h11, 32'h22, 32'h0, 1'b0, ALU_SUB, 1'b0);
    exmem_reg_write = 1; exmem_rd = 3; exmem_alu_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_wb_data = 32'hBB;
    #1;
    chk("fwd_both_a", SrcA, 32'hAA);
    chk("fwd_both_b", SrcB, 32'hAA);
    chk("fwd_both_st", ex_store_data, 32'hAA);
    exmem_reg_write = 0; #1;
    chk("fwd_memwb_a", SrcA, 32'hBB);
    chk("fwd_memwb_st", ex_store_data, 32'hBB);
    memwb_reg_write = 0; #1;
    chk("fwd_none_a", SrcA, 32'h11);
    chk("fwd_none_b", SrcB, 32'h22);

    capture(5'd0, 5'd0, 5'd8, 32'h33, 32'h55, 32'h0, 1'b0, ALU_OR, 1'b0);
    exmem_reg_write = 1; exmem_rd = 0; exmem_alu_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 0; memwb_wb_data = 32'hBB;
    #1;
    chk("x0_srcb", SrcB, 32'h55);
    chk("x0_srca", SrcA, 32'h33);

    capture(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 32'h10, 1'b1, ALU_ADD, 1'b1);
    chk("lw_mem_read", 32'(ex_mem_read), 1);
    @(negedge clk);
    idle();
    id_valid = 1; id_rs1 = 5; id_rs2 = 4; id_rd = 9; id_reg_write = 1; id_operation = ALU_ADD;
    #1;
    chk("lu_stall", 32'(load_use_stall), 1);
    id_valid = 0; #1;
    chk("lu_gated", 32'(load_use_stall), 0);
    id_valid = 1;
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 0);
    chk("lu_bubble_rd", 32'(ex_rd), 0);
    chk("lu_clear", 32'(load_use_stall), 0);

    capture(5'd1, 5'd2, 5'd6, 32'h44, 32'h0, 32'h1, 1'b1, ALU_ADD, 1'b0);
    @(negedge clk);
    flush_in = 1; stall_in = 1;
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_op", 32'(Operation), 0);
    chk("flush_rw", 32'(ex_reg_write), 0);

    capture(5'd1, 5'd2, 5'd6, 32'd9, 32'd0, 32'd3, 1'b1, ALU_XOR, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      stall_in = 1; id_rs1_data = 32'(100 + c); id_imm = 32'(200 + c); id_operation = ALU_BLT;
      tick();
      chk("stall_srca", SrcA, 9);
      chk("stall_srcb", SrcB, 3);
      chk("stall_op", 32'(Operation), 32'(ALU_XOR));
    end

    capture(5'd1, 5'd2, 5'd6, 32'h77, 32'h0, 32'h5, 1'b1, ALU_ADD, 1'b0);
    chk("prerst_valid", 32'(ex_valid), 1);
    @(negedge clk); #2;
    rst_n = 0; #1;
    chk("arst_srca", SrcA, 0);
    chk("arst_srcb", SrcB, 0);
    chk("arst_op", 32'(Operation), 0);
    chk("arst_valid", 32'(ex_valid), 0);
    tick();
    chk("arst_hold_valid", 32'(ex_valid), 0);
    @(negedge clk); rst_n = 1; #1;
    chk("arst_rel_valid", 32'(ex_valid), 0);
    tick();
    chk("post_rst_valid", 32'(ex_valid), 1);
    chk("post_rst_srca", SrcA, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
